// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, PC-source codes,
// stage bit positions and the stall/flush vectors for each hazard class.
package pipe_ctrl_pkg;

  localparam int unsigned NUM_STG = 5;

  localparam int unsigned STG_PC   = 0;
  localparam int unsigned STG_IFID = 1;
  localparam int unsigned STG_IDEX = 2;
  localparam int unsigned STG_EXMEM = 3;
  localparam int unsigned STG_MEMWB = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXC      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_EXC = 2'd3
  } pc_sel_t;

  localparam logic [NUM_STG-1:0] VEC_NONE    = '0;
  localparam logic [NUM_STG-1:0] FLUSH_RESET = '1;
  localparam logic [NUM_STG-1:0] STALL_LU    = NUM_STG'((1 << STG_PC) | (1 << STG_IFID));
  localparam logic [NUM_STG-1:0] FLUSH_LU    = NUM_STG'(1 << STG_IDEX);
  localparam logic [NUM_STG-1:0] FLUSH_JMP   = NUM_STG'(1 << STG_IFID);
  localparam logic [NUM_STG-1:0] FLUSH_BR    = NUM_STG'((1 << STG_IFID) | (1 << STG_IDEX));
  localparam logic [NUM_STG-1:0] FLUSH_EXC   = NUM_STG'((1 << STG_IFID) | (1 << STG_IDEX) | (1 << STG_EXMEM));
  localparam logic [NUM_STG-1:0] STALL_MEM   = NUM_STG'((1 << STG_PC) | (1 << STG_IFID) | (1 << STG_IDEX) | (1 << STG_EXMEM));
  localparam logic [NUM_STG-1:0] FLUSH_MEM   = NUM_STG'(1 << STG_MEMWB);

  typedef struct packed {
    logic [NUM_STG-1:0] stall;
    logic [NUM_STG-1:0] flush;
    pc_sel_t            pc_sel;
    state_t             nxt;
  } decode_t;

  // Priority merge of hazard requests as seen from the RUN state.
  function automatic decode_t run_decode(input logic exc, input logic dmem_stall,
                                         input logic br, input logic jmp, input logic lu);
    decode_t d;
    d.stall  = VEC_NONE;
    d.flush  = VEC_NONE;
    d.pc_sel = PC_SEQ;
    d.nxt    = RUN;
    if (exc) begin
      d.flush  = FLUSH_EXC;
      d.pc_sel = PC_EXC;
      d.nxt    = EXC;
    end else if (dmem_stall) begin
      d.stall = STALL_MEM;
      d.flush = FLUSH_MEM;
      d.nxt   = MEM_WAIT;
    end else if (br) begin
      d.flush  = FLUSH_BR;
      d.pc_sel = PC_BR;
    end else if (jmp) begin
      d.flush  = FLUSH_JMP;
      d.pc_sel = PC_JMP;
    end else if (lu) begin
      d.stall = STALL_LU;
      d.flush = FLUSH_LU;
    end
    return d;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl_sched.sv
// Pipeline sequencer: merges hazard requests into per-stage stall/flush and
// PC-source select, sequences data-memory waits with a timeout trap.
module pipe_ctrl_sched
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             jump_id,
  input  logic             branch_taken_ex,
  input  logic             exc_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [4:0]       stall,
  output logic [4:0]       flush,
  output logic [1:0]       pc_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  decode_t           dec;
  logic              exc_eff;

  // The cycle after a trap masks exc_ex so the same instruction cannot re-trap.
  assign exc_eff = exc_ex && (state != EXC);

  always_comb begin
    dec         = run_decode(exc_eff, dmem_req && !dmem_ready, branch_taken_ex, jump_id, load_use);
    stall       = dec.stall;
    flush       = dec.flush;
    pc_sel      = dec.pc_sel;
    mem_timeout = 1'b0;
    state_nxt   = dec.nxt;
    wait_nxt    = (dec.nxt == MEM_WAIT) ? WAIT_W'(1) : '0;
    unique case (state)
      RUN, EXC: ;
      MEM_WAIT: begin
        // wait_cnt counts completed wait cycles; this one is number wait_cnt+1.
        if (!dmem_ready) begin
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            stall       = VEC_NONE;
            flush       = FLUSH_EXC;
            pc_sel      = PC_EXC;
            mem_timeout = 1'b1;
            state_nxt   = EXC;
            wait_nxt    = '0;
          end else begin
            stall     = STALL_MEM;
            flush     = FLUSH_MEM;
            pc_sel    = PC_SEQ;
            state_nxt = MEM_WAIT;
            wait_nxt  = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
    if (reset) begin
      stall       = VEC_NONE;
      flush       = FLUSH_RESET;
      pc_sel      = PC_SEQ;
      mem_timeout = 1'b0;
      state_nxt   = RUN;
      wait_nxt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .clear(reset),
    .en   (stall[STG_PC]),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl_sched.sv
// Directed plus randomized check of pipe_ctrl_sched against a cycle-level
// behavioural model of the hazard priority and memory-wait rules.
module tb_pipe_ctrl_sched;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          load_use;
  logic          jump_id;
  logic          branch_taken_ex;
  logic          exc_ex;
  logic          dmem_req;
  logic          dmem_ready;
  logic [4:0]    stall;
  logic [4:0]    flush;
  logic [1:0]    pc_sel;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl_sched #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_use       (load_use),
    .jump_id        (jump_id),
    .branch_taken_ex(branch_taken_ex),
    .exc_ex         (exc_ex),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .stall          (stall),
    .flush          (flush),
    .pc_sel         (pc_sel),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: are we in a memory wait, how many wait cycles have elapsed,
  // did the previous cycle trap, and the number of PC-stall cycles so far.
  bit m_waiting  = 0;
  int m_waits    = 0;
  bit m_trapped  = 0;
  int m_cnt      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit r, input bit lu, input bit j, input bit br,
                        input bit ex, input bit rq, input bit rd);
    reset = r; load_use = lu; jump_id = j; branch_taken_ex = br;
    exc_ex = ex; dmem_req = rq; dmem_ready = rd;
  endtask

  // One clock: predict, check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [4:0] es, ef;
    logic [1:0] ep;
    logic       et;
    bit         ex_live, dm_stall;
    es = 5'b0; ef = 5'b0; ep = 2'b00; et = 1'b0;
    ex_live  = exc_ex && !m_trapped;
    dm_stall = dmem_req && !dmem_ready;
    if (reset) begin
      ef = 5'b11111;
    end else if (m_waiting && !dmem_ready) begin
      if (m_waits + 1 == TO) begin
        ef = 5'b01110; ep = 2'b11; et = 1'b1;
      end else begin
        es = 5'b01111; ef = 5'b10000;
      end
    end else if (ex_live) begin
      ef = 5'b01110; ep = 2'b11;
    end else if (dm_stall) begin
      es = 5'b01111; ef = 5'b10000;
    end else if (branch_taken_ex) begin
      ef = 5'b00110; ep = 2'b01;
    end else if (jump_id) begin
      ef = 5'b00010; ep = 2'b10;
    end else if (load_use) begin
      es = 5'b00011; ef = 5'b00100;
    end

    @(negedge clk);
    check("stall", 32'(stall), 32'(es));
    check("flush", 32'(flush), 32'(ef));
    check("pc_sel", 32'(pc_sel), 32'(ep));
    check("mem_timeout", 32'(mem_timeout), 32'(et));
    check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));

    @(posedge clk);
    if (reset) begin
      m_waiting = 0; m_waits = 0; m_trapped = 0; m_cnt = 0;
    end else begin
      if (es[0] && m_cnt < CMAX) m_cnt++;
      if (m_waiting && !dmem_ready) begin
        if (et) begin
          m_waiting = 0; m_waits = 0; m_trapped = 1;
        end else begin
          m_waits++;
        end
      end else if (ex_live) begin
        m_waiting = 0; m_waits = 0; m_trapped = 1;
      end else if (dm_stall) begin
        m_waiting = 1; m_waits = 1; m_trapped = 0;
      end else begin
        m_waiting = 0; m_waits = 0; m_trapped = 0;
      end
    end
    #1;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset held two cycles, then release.
    cycle(); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();

    // Load-use, then idle to observe the stall count.
    set_in(0, 1, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    check("stall_cnt_after_lu", 32'(stall_cnt), 32'd1);

    // Branch beats jump and load-use.
    set_in(0, 1, 1, 1, 0, 0, 0); cycle();
    set_in(0, 1, 1, 0, 0, 0, 0); cycle();

    // Memory wait of three cycles then completion.
    repeat (3) begin set_in(0, 0, 0, 0, 0, 1, 0); cycle(); end
    set_in(0, 0, 0, 0, 0, 1, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();
    check("stall_cnt_after_wait", 32'(stall_cnt), 32'd4);

    // Timeout on the 4th wait cycle, then EXC masks a held exc_ex.
    repeat (4) begin set_in(0, 0, 0, 0, 0, 1, 0); cycle(); end
    set_in(0, 0, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();

    // Exception beats memory stall; held exc_ex does not re-trap.
    set_in(0, 0, 0, 0, 1, 1, 0); cycle();
    set_in(0, 0, 0, 0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0); cycle();

    // Reset in the middle of a wait, and stray dmem_ready.
    repeat (2) begin set_in(0, 0, 0, 0, 0, 1, 0); cycle(); end
    set_in(1, 0, 0, 0, 0, 1, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1); cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
             $urandom_range(4) == 0, $urandom_range(7) == 0, $urandom_range(2) == 0,
             $urandom_range(1) == 0);
      cycle();
    end

    // Saturation of the stall counter.
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();
    set_in(0, 1, 0, 0, 0, 0, 0);
    repeat (CMAX + 20) cycle();
    check("stall_cnt_saturated", 32'(stall_cnt), 32'(CMAX));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
